mem_slave_ws: RTL and testbench
===============================

Name: mem_slave_ws

Overview:
Parametrised single-port memory slave for the SEL / WR_RDbar / ADDR / WDATA / READY / RDATA bus used by our memory testbench. It is the next generation of the fixed 8-bit-address, 16-bit-data memory: data width, address width and depth are configurable. It adds programmable wait states, byte-lane write enables, an out-of-range error response and transfer abort. It sits behind the memory bus as the DUT that drivers and monitors attach to.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8.
ADDR_W, 8, address width in bits.
DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**ADDR_W.
WS_W, 4, width of the runtime wait-state field.

Ports:
clk  input  1  clock; all logic on the rising edge.
RST  input  1  asynchronous, active-high reset.
SEL  input  1  transfer request; held high by the master until READY is seen.
WR_RDbar  input  1  1 = write, 0 = read.
ADDR  input  ADDR_W  word address.
WDATA  input  DATA_W  write data.
BE  input  DATA_W/8  byte-lane write enables; ignored for reads.
WS  input  WS_W  wait-state count for this transfer; sampled at capture.
READY  output  1  one-cycle transfer-complete pulse.
RDATA  output  DATA_W  read data; valid while READY=1 on a read.
ERR  output  1  high together with READY when ADDR >= DEPTH.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE, READY=0, ERR=0, RDATA=0, wait counter=0. Memory contents are not cleared. Any in-flight transfer is discarded and no write occurs.
- All outputs are registered.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: at a rising edge with SEL=1, capture WR_RDbar, ADDR, WDATA, BE and WS.
  - If WS=0, go to RESP.
  - Otherwise load counter=WS and go to WAIT.
  - With SEL=0, stay in IDLE.
- WAIT: at each edge decrement the counter.
  - When the counter reaches 1 with SEL still high, go to RESP.
  - If SEL=0 at any WAIT edge, abort: return to IDLE with no write and no READY.
  - Changes on ADDR, WDATA, BE, WR_RDbar and WS during WAIT are ignored; the captured values are used.
- Entry edge into RESP:
  - READY<=1.
  - ERR<=(captured ADDR >= DEPTH).
  - Write with ERR=0: mem[ADDR] byte lane i <= WDATA lane i for each BE[i]=1; other lanes are unchanged.
  - Read with ERR=0: RDATA<=mem[ADDR], reflecting all earlier completed writes.
  - ERR=1: no write. On a read, RDATA<=0.
- RESP lasts one cycle. Next edge: READY<=0, ERR<=0, go to IDLE. RDATA holds its value until the next read completes.
- Latency: with SEL first sampled high at edge N, READY is high during the cycle after edge N+WS.
- Bubble rule: the master drops SEL, or presents the next transfer, at the edge where it samples READY=1. IDLE samples SEL one edge later, so there is a minimum of one idle cycle between back-to-back transfers.
- SEL dropping during RESP has no effect; the completed transfer stands.
- A write with BE=0 completes with READY but changes no memory.
- Address bits above log2(DEPTH) are only used for the ERR check; there is no wrap-around aliasing.

Test Plan:
- Reset, then write ADDR=0x10, WDATA=0xBEEF, BE=2'b11, WS=0; then read 0x10 -> READY pulses one cycle each, one cycle after capture; read returns RDATA=0xBEEF with ERR=0.
- Write 0x1234 to ADDR 0x20; then write 0xAB00 with BE=2'b10; then read 0x20 -> RDATA=0xAB34.
- WS=3 read of a known location -> READY rises exactly 4 cycles after the SEL capture edge; READY stays low during the 3 WAIT cycles.
- DEPTH=200: write ADDR=0xC8 -> READY=1 and ERR=1 in the same cycle, no memory change; read 0xC8 -> RDATA=0 and ERR=1; read 0xC7 returns its prior value.
- WS=5 write of 0x5555 to a location holding 0x1111, with SEL dropped after 2 WAIT cycles -> no READY, FSM back in IDLE; subsequent read returns 0x1111.
- Assert RST mid-WAIT of a write -> READY, ERR and RDATA go to 0 immediately; the location keeps its old value; a new transfer after RST=0 completes normally.

Source files
------------

// File: rtl/mem_slave_ws.sv
// Single-port memory slave with programmable wait states, byte-lane writes,
// out-of-range error response and abort on SEL drop during the wait phase.
module mem_slave_ws #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int WS_W   = 4
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                SEL,
    input  logic                WR_RDbar,
    input  logic [ADDR_W-1:0]   ADDR,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] BE,
    input  logic [WS_W-1:0]     WS,
    output logic                READY,
    output logic [DATA_W-1:0]   RDATA,
    output logic                ERR
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [WS_W-1:0] WS_ONE  = WS_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [WS_W-1:0]     cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // With WS=0 the transfer completes on the capture edge itself, so the
    // live bus values are used there; afterwards the captured copies are.
    logic                eff_wr;
    logic [ADDR_W-1:0]   eff_addr;
    logic [DATA_W-1:0]   eff_wdata;
    logic [BE_W-1:0]     eff_be;
    logic [IDX_W-1:0]    idx;
    logic                oor;
    logic                fire;
    logic                mem_we;

    always_comb begin
        if (state_q == S_IDLE) begin
            eff_wr    = WR_RDbar;
            eff_addr  = ADDR;
            eff_wdata = WDATA;
            eff_be    = BE;
        end else begin
            eff_wr    = wr_q;
            eff_addr  = addr_q;
            eff_wdata = wdata_q;
            eff_be    = be_q;
        end
        idx = eff_addr[IDX_W-1:0];
        oor = ({1'b0, eff_addr} >= DEPTH_C);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (SEL) begin
                    wr_d    = WR_RDbar;
                    addr_d  = ADDR;
                    wdata_d = WDATA;
                    be_d    = BE;
                    if (WS == '0) begin
                        fire    = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = WS;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - WS_ONE;
                if (!SEL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == WS_ONE) begin
                    fire    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = fire;
        err_d   = fire & oor;
        rdata_d = rdata_q;
        if (fire && !eff_wr)
            rdata_d = oor ? '0 : mem[idx];
        mem_we = fire & eff_wr & ~oor;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is never cleared; RST only blocks a write landing on its edge.
    always_ff @(posedge clk) begin
        if (mem_we && !RST) begin
            for (int i = 0; i < BE_W; i++) begin
                if (eff_be[i])
                    mem[idx][8*i +: 8] <= eff_wdata[8*i +: 8];
            end
        end
    end

    assign READY = ready_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;
endmodule

// File: tb/tb_mem_slave_ws.sv
// Directed bench for mem_slave_ws (DEPTH=200): latency, byte lanes, error
// response, abort and asynchronous reset.
module tb_mem_slave_ws;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 200;
    localparam int WS_W   = 4;

    logic              clk = 1'b0;
    logic              RST;
    logic              SEL;
    logic              WR_RDbar;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] WDATA;
    logic [1:0]        BE;
    logic [WS_W-1:0]   WS;
    logic              READY;
    logic [DATA_W-1:0] RDATA;
    logic              ERR;

    int n_cmp = 0;
    int n_bad = 0;

    mem_slave_ws #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WS_W(WS_W)) dut (
        .clk(clk), .RST(RST), .SEL(SEL), .WR_RDbar(WR_RDbar), .ADDR(ADDR),
        .WDATA(WDATA), .BE(BE), .WS(WS), .READY(READY), .RDATA(RDATA), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transfer; bus inputs are scrambled while waiting to prove the
    // captured copies are used. Returns latency in edges after capture.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [15:0] d,
                        input logic [1:0] be, input logic [3:0] ws,
                        output logic [15:0] rd, output logic er, output int lat,
                        output logic rdy_after);
        @(negedge clk);
        SEL = 1'b1; WR_RDbar = wr; ADDR = a; WDATA = d; BE = be; WS = ws;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!READY && lat < 40) begin
            lat++;
            WR_RDbar = 1'($urandom);
            ADDR     = 8'($urandom);
            WDATA    = 16'($urandom);
            BE       = 2'($urandom);
            WS       = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        rd = RDATA;
        er = ERR;
        SEL = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rdy_after = READY;
    endtask

    task automatic run(input string tag, input logic wr, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be, input logic [3:0] ws,
                       input logic [15:0] exp_rd, input logic exp_err);
        logic [15:0] rd;
        logic        er, ra;
        int          lat;
        xfer(wr, a, d, be, ws, rd, er, lat, ra);
        chk({tag, ".lat"},   32'(lat), 32'(ws));
        chk({tag, ".err"},   32'(er),  32'(exp_err));
        chk({tag, ".rdata"}, 32'(rd),  32'(exp_rd));
        chk({tag, ".pulse"}, 32'(ra),  32'd0);
    endtask

    initial begin
        logic seen;
        RST = 1'b1; SEL = 1'b0; WR_RDbar = 1'b0; ADDR = '0; WDATA = '0; BE = '0; WS = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(READY), 32'd0);
        chk("rst.err",   32'(ERR),   32'd0);
        chk("rst.rdata", 32'(RDATA), 32'd0);
        RST = 1'b0;

        run("w10",     1, 8'h10, 16'hBEEF, 2'b11, 4'd0, 16'h0000, 0);
        run("r10",     0, 8'h10, 16'h0000, 2'b11, 4'd0, 16'hBEEF, 0);
        run("w20",     1, 8'h20, 16'h1234, 2'b11, 4'd0, 16'hBEEF, 0);
        run("w20hi",   1, 8'h20, 16'hAB00, 2'b10, 4'd1, 16'hBEEF, 0);
        run("r20",     0, 8'h20, 16'h0000, 2'b00, 4'd0, 16'hAB34, 0);
        run("w20be0",  1, 8'h20, 16'hFFFF, 2'b00, 4'd2, 16'hAB34, 0);
        run("w21lo",   1, 8'h21, 16'h0F0F, 2'b01, 4'd0, 16'hAB34, 0);
        run("r10ws3",  0, 8'h10, 16'h0000, 2'b11, 4'd3, 16'hBEEF, 0);
        run("r20b",    0, 8'h20, 16'h0000, 2'b11, 4'd0, 16'hAB34, 0);
        run("wC7",     1, 8'hC7, 16'h7777, 2'b11, 4'd0, 16'hAB34, 0);
        run("wC8",     1, 8'hC8, 16'h1357, 2'b11, 4'd0, 16'hAB34, 1);
        run("rC8",     0, 8'hC8, 16'h0000, 2'b11, 4'd2, 16'h0000, 1);
        run("rC7",     0, 8'hC7, 16'h0000, 2'b11, 4'd0, 16'h7777, 0);
        run("rFF",     0, 8'hFF, 16'h0000, 2'b11, 4'd1, 16'h0000, 1);
        run("w30",     1, 8'h30, 16'h1111, 2'b11, 4'd0, 16'h0000, 0);

        // Abort: SEL dropped after two WAIT edges of a WS=5 write.
        @(negedge clk);
        SEL = 1'b1; WR_RDbar = 1'b1; ADDR = 8'h30; WDATA = 16'h5555; BE = 2'b11; WS = 4'd5;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        SEL = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            seen = seen | READY;
        end
        chk("abort.noready", 32'(seen), 32'd0);
        run("r30",     0, 8'h30, 16'h0000, 2'b11, 4'd0, 16'h1111, 0);

        // Reset in the middle of a WAIT write.
        run("w40",     1, 8'h40, 16'h2222, 2'b11, 4'd0, 16'h1111, 0);
        run("r10c",    0, 8'h10, 16'h0000, 2'b11, 4'd0, 16'hBEEF, 0);
        @(negedge clk);
        SEL = 1'b1; WR_RDbar = 1'b1; ADDR = 8'h40; WDATA = 16'h9999; BE = 2'b11; WS = 4'd4;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #2 RST = 1'b1;
        #1;
        chk("rstw.ready", 32'(READY), 32'd0);
        chk("rstw.err",   32'(ERR),   32'd0);
        chk("rstw.rdata", 32'(RDATA), 32'd0);
        SEL = 1'b0;
        @(posedge clk); @(negedge clk);
        RST = 1'b0;
        run("r40",     0, 8'h40, 16'h0000, 2'b11, 4'd1, 16'h2222, 0);

        // Reset while an error response is on the bus clears it at once.
        @(negedge clk);
        SEL = 1'b1; WR_RDbar = 1'b0; ADDR = 8'hC8; WS = 4'd0;
        @(posedge clk);
        #1;
        chk("resp.ready", 32'(READY), 32'd1);
        chk("resp.err",   32'(ERR),   32'd1);
        RST = 1'b1;
        #1;
        chk("rstr.ready", 32'(READY), 32'd0);
        chk("rstr.err",   32'(ERR),   32'd0);
        SEL = 1'b0;
        @(negedge clk);
        RST = 1'b0;
        run("r10d",    0, 8'h10, 16'h0000, 2'b11, 4'd2, 16'hBEEF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
